// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit: data-memory stage with MEM-MEM forwarding, 16/32-bit access
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  double_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [2*DATA_W-1:0]   write_data_in,
  input  logic [DATA_W-1:0]     wb_data_in,
  input  logic                  forward_data_to_address_in,
  input  logic                  forward_data_to_write_data_in,
  output logic [2*DATA_W-1:0]   read_data_out,
  output logic                  read_valid_out,
  output logic                  stall_out
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   r_next_addr;
  logic [DATA_W-1:0]   r_hi_data;
  logic [DATA_W-1:0]   r_lo_rd;
  logic                r_dbl_wr;
  logic                r_dbl_rd;
  logic [2*DATA_W-1:0] r_read_data;
  logic                r_read_valid;

  logic [ADDR_W-1:0]   w_eff_addr;
  logic [DATA_W-1:0]   w_eff_lo;
  logic                w_req_wr;
  logic                w_req_rd;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_stall;

  assign w_eff_addr = forward_data_to_address_in ? wb_data_in[ADDR_W-1:0] : addr_in;
  assign w_eff_lo   = forward_data_to_write_data_in ? wb_data_in : write_data_in[DATA_W-1:0];
  // A simultaneous write request suppresses the read.
  assign w_req_wr   = mem_write_in;
  assign w_req_rd   = mem_read_in & ~mem_write_in;

  always_comb begin
    w_state_nxt = r_state;
    w_mem_addr  = w_eff_addr;
    w_mem_wdata = w_eff_lo;
    w_mem_we    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_mem_we = w_req_wr;
        if (double_in && (w_req_wr || w_req_rd)) begin
          w_stall     = 1'b1;
          w_state_nxt = SECOND;
        end
      end
      SECOND: begin
        w_mem_addr  = r_next_addr;
        w_mem_wdata = r_hi_data;
        w_mem_we    = r_dbl_wr;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_word = r_mem[w_mem_addr];

  // Array is deliberately left out of reset; a write is blocked while reset is held.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_next_addr  <= '0;
      r_hi_data    <= '0;
      r_lo_rd      <= '0;
      r_dbl_wr     <= 1'b0;
      r_dbl_rd     <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_state_nxt == SECOND) begin
          r_next_addr <= w_eff_addr + ADDR_W'(1);
          r_hi_data   <= write_data_in[2*DATA_W-1:DATA_W];
          r_dbl_wr    <= w_req_wr;
          r_dbl_rd    <= w_req_rd;
          r_lo_rd     <= w_rd_word;
        end else if (w_req_rd) begin
          r_read_data  <= {{DATA_W{1'b0}}, w_rd_word};
          r_read_valid <= 1'b1;
        end
      end else if (r_dbl_rd) begin
        // Both halves land together so no half-updated result is ever exposed.
        r_read_data  <= {w_rd_word, r_lo_rd};
        r_read_valid <= 1'b1;
      end
    end
  end

  assign read_data_out  = r_read_data;
  assign read_valid_out = r_read_valid;
  assign stall_out      = w_stall & rst_n_in;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit: directed + random checks against a word-array model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int DW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read, mem_write, dbl;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [15:0]   wb;
  logic          fa, fd;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          stall;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_in                        (clk),
    .rst_n_in                      (rst_n),
    .mem_read_in                   (mem_read),
    .mem_write_in                  (mem_write),
    .double_in                     (dbl),
    .addr_in                       (addr),
    .write_data_in                 (wdata),
    .wb_data_in                    (wb),
    .forward_data_to_address_in    (fa),
    .forward_data_to_write_data_in (fd),
    .read_data_out                 (rdata),
    .read_valid_out                (rvalid),
    .stall_out                     (stall)
  );

  int total = 0;
  int bad   = 0;

  // Reference: plain word array plus the result register/valid visible this cycle.
  logic [15:0] m_mem [0:2047];
  logic [31:0] e_data;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic db, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [15:0] w, input logic f_a, input logic f_d);
    mem_read = rd; mem_write = wr; dbl = db; addr = a; wdata = wd; wb = w; fa = f_a; fd = f_d;
  endtask

  task automatic cycle(input logic exp_stall, input string tag);
    @(negedge clk);
    chk({tag, ":stall"}, {31'b0, stall}, {31'b0, exp_stall});
    chk({tag, ":valid"}, {31'b0, rvalid}, {31'b0, e_valid});
    chk({tag, ":data"}, rdata, e_data);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] eff_a(input logic [AW-1:0] a, input logic [15:0] w, input logic f_a);
    return f_a ? w[AW-1:0] : a;
  endfunction

  task automatic single(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [15:0] w, input logic f_a, input logic f_d, input string tag);
    logic [AW-1:0] ea;
    drive(rd, wr, 1'b0, a, wd, w, f_a, f_d);
    cycle(1'b0, tag);
    ea = eff_a(a, w, f_a);
    if (wr) begin
      m_mem[ea] = f_d ? w : wd[15:0];
      e_valid = 1'b0;
    end else if (rd) begin
      e_data  = {16'h0, m_mem[ea]};
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
  endtask

  task automatic idle(input string tag);
    single(1'b0, 1'b0, AW'($urandom), $urandom, 16'($urandom), 1'b0, 1'b0, tag);
  endtask

  task automatic second_garbage();
    drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom, 16'($urandom),
          1'($urandom), 1'($urandom));
  endtask

  // Caller guarantees rd|wr so the unit actually enters its second cycle.
  task automatic dbl_op(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [15:0] w, input logic f_a, input logic f_d, input string tag);
    logic [AW-1:0] ea, na;
    logic [15:0]   lo_save;
    drive(rd, wr, 1'b1, a, wd, w, f_a, f_d);
    cycle(1'b1, {tag, "/1"});
    ea = eff_a(a, w, f_a);
    na = ea + AW'(1);
    if (wr) m_mem[ea] = f_d ? w : wd[15:0];
    lo_save = m_mem[ea];
    e_valid = 1'b0;
    second_garbage();
    cycle(1'b0, {tag, "/2"});
    if (wr) begin
      m_mem[na] = wd[31:16];
      e_valid = 1'b0;
    end else begin
      e_data  = {m_mem[na], lo_save};
      e_valid = 1'b1;
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [15:0]   rw;
    logic          rfa;
    int            kind;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    e_data = '0; e_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:stall", {31'b0, stall}, 32'd0);
    chk("reset:valid", {31'b0, rvalid}, 32'd0);
    chk("reset:data", rdata, 32'd0);
    rst_n = 1'b1;

    // Single write then read, valid exactly one cycle
    single(1'b0, 1'b1, 11'h010, 32'h0000_BEEF, 16'h0, 1'b0, 1'b0, "sw010");
    single(1'b1, 1'b0, 11'h010, 32'h0, 16'h0, 1'b0, 1'b0, "sr010");
    idle("after_sr010");
    idle("valid_drop");

    // Double write then double read, plus high word read separately
    dbl_op(1'b0, 1'b1, 11'h020, 32'h1234_5678, 16'h0, 1'b0, 1'b0, "dw020");
    dbl_op(1'b1, 1'b0, 11'h020, 32'h0, 16'h0, 1'b0, 1'b0, "dr020");
    idle("after_dr020");
    single(1'b1, 1'b0, 11'h021, 32'h0, 16'h0, 1'b0, 1'b0, "sr021");
    idle("after_sr021");

    // Address and write-data forwarding
    single(1'b0, 1'b1, 11'h005, 32'h1111, 16'h0, 1'b0, 1'b0, "init005");
    single(1'b0, 1'b1, 11'h030, 32'h2222, 16'h0, 1'b0, 1'b0, "init030");
    single(1'b0, 1'b1, 11'h005, 32'hAAAA, 16'h0030, 1'b1, 1'b0, "fwd_addr");
    single(1'b1, 1'b0, 11'h030, 32'h0, 16'h0, 1'b0, 1'b0, "rd030");
    single(1'b1, 1'b0, 11'h005, 32'h0, 16'h0, 1'b0, 1'b0, "rd005");
    single(1'b0, 1'b1, 11'h005, 32'hAAAA, 16'h7777, 1'b0, 1'b1, "fwd_data");
    single(1'b1, 1'b0, 11'h005, 32'h0, 16'h0, 1'b0, 1'b0, "rd005b");

    // Forward selects only honoured in the first cycle
    dbl_op(1'b0, 1'b1, 11'h040, 32'hCAFE_0000, 16'h0050, 1'b1, 1'b1, "dw_fwd");
    dbl_op(1'b1, 1'b0, 11'h050, 32'h0, 16'h0, 1'b0, 1'b0, "dr050");

    // Address wrap at the top of memory
    dbl_op(1'b0, 1'b1, 11'h7FF, 32'hA5A5_5A5A, 16'h0, 1'b0, 1'b0, "dw7ff");
    single(1'b1, 1'b0, 11'h7FF, 32'h0, 16'h0, 1'b0, 1'b0, "sr7ff");
    single(1'b1, 1'b0, 11'h000, 32'h0, 16'h0, 1'b0, 1'b0, "sr000");
    dbl_op(1'b1, 1'b0, 11'h7FF, 32'h0, 16'h0, 1'b0, 1'b0, "dr7ff");

    // Read and write together: write wins, no valid pulse
    single(1'b1, 1'b1, 11'h070, 32'h0000_3C3C, 16'h0, 1'b0, 1'b0, "rw070");
    idle("after_rw070");
    single(1'b1, 1'b0, 11'h070, 32'h0, 16'h0, 1'b0, 1'b0, "sr070");

    // Reset during the second cycle of a double write
    single(1'b0, 1'b1, 11'h060, 32'h0001, 16'h0, 1'b0, 1'b0, "init060");
    single(1'b0, 1'b1, 11'h061, 32'h2222, 16'h0, 1'b0, 1'b0, "init061");
    drive(1'b0, 1'b1, 1'b1, 11'h060, 32'h9999_8888, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, "dw060_rst/1");
    m_mem[11'h060] = 16'h8888;
    second_garbage();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sec:stall", {31'b0, stall}, 32'd0);
    chk("rst_sec:valid", {31'b0, rvalid}, 32'd0);
    chk("rst_sec:data", rdata, 32'd0);
    e_data = '0; e_valid = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    single(1'b1, 1'b0, 11'h061, 32'h0, 16'h0, 1'b0, 1'b0, "sr061");
    single(1'b1, 1'b0, 11'h060, 32'h0, 16'h0, 1'b0, 1'b0, "sr060");
    dbl_op(1'b0, 1'b1, 11'h080, 32'h4321_8765, 16'h0, 1'b0, 1'b0, "dw080");
    dbl_op(1'b1, 1'b0, 11'h080, 32'h0, 16'h0, 1'b0, 1'b0, "dr080");

    // Random traffic over a pre-initialised window
    for (int i = 0; i < 16; i++) begin
      single(1'b0, 1'b1, AW'(11'h100 + i), $urandom, 16'h0, 1'b0, 1'b0, "rinit");
    end
    for (int i = 0; i < 300; i++) begin
      rfa  = 1'($urandom);
      ra   = AW'(11'h100 + $urandom_range(0, 14));
      rw   = rfa ? 16'(11'h100 + $urandom_range(0, 14)) : 16'($urandom);
      kind = $urandom_range(0, 5);
      case (kind)
        0: single(1'b1, 1'b0, ra, $urandom, rw, rfa, 1'($urandom), "rnd_sr");
        1: single(1'b0, 1'b1, ra, $urandom, rw, rfa, 1'($urandom), "rnd_sw");
        2: dbl_op(1'b1, 1'b0, ra, $urandom, rw, rfa, 1'($urandom), "rnd_dr");
        3: dbl_op(1'b0, 1'b1, ra, $urandom, rw, rfa, 1'($urandom), "rnd_dw");
        4: single(1'b1, 1'b1, ra, $urandom, rw, rfa, 1'($urandom), "rnd_rw");
        default: idle("rnd_idle");
      endcase
    end
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
